// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed BCD digit scanner with inter-digit blanking and frame-synchronous value update.
// Optional SEG7_LEAD_ZERO_BLANK_EN enables leading-zero suppression.
module seg7_scan_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000,
  parameter int BLANK    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  output logic [3:0]            bcd_q,
  output logic [DIGITS-1:0]     digit_en_n,
  output logic                  blank,
  output logic                  pending,
  output logic                  frame_start
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int CW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  typedef enum logic {BLANKING, SHOW} state_t;
  state_t state, n_state;
  logic [4*DIGITS-1:0] shadow, active, n_active;
  logic [IW-1:0] idx, n_idx;
  logic [CW-1:0] cnt, n_cnt;
  logic [3:0] n_nib;
  logic last, boundary, show;
  // Outputs are registered from next-state values so they change exactly on slot/phase edges.
  always_comb begin
    last     = cnt == CW'(PRESCALE - 1);
    boundary = last && idx == IW'(DIGITS - 1);
    n_cnt    = last ? '0 : cnt + CW'(1);
    n_idx    = !last ? idx : boundary ? '0 : idx + IW'(1);
    n_active = !boundary ? active : load ? value : pending ? shadow : active;
    n_state  = (state == BLANKING && cnt == CW'(BLANK - 1)) ? SHOW :
               (state == SHOW && last) ? BLANKING : state;
    n_nib    = n_active[4*n_idx +: 4];
    show     = n_state == SHOW && n_nib <= 4'd9;
`ifdef SEG7_LEAD_ZERO_BLANK_EN
    show     = show && (n_idx == '0 || (n_active >> {n_idx, 2'b00}) != '0);
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= BLANKING;
    else state <= n_state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      shadow      <= '0;
      active      <= '0;
      idx         <= '0;
      cnt         <= '0;
      bcd_q       <= '0;
      digit_en_n  <= '1;
      blank       <= 1'b1;
      pending     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      shadow      <= load ? value : shadow;
      active      <= n_active;
      idx         <= n_idx;
      cnt         <= n_cnt;
      bcd_q       <= n_nib;
      digit_en_n  <= show ? ~(DIGITS'(1) << n_idx) : '1;
      blank       <= !show;
      pending     <= boundary ? 1'b0 : load ? 1'b1 : pending;
      frame_start <= n_idx == IW'(DIGITS - 1) && n_cnt == CW'(PRESCALE - 1);
    end
endmodule
